// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among NUM_REQ requesters.
// Arbitration happens in IDLE; the winner is granted for one WRITE cycle, and its word commits at the end of that cycle.
module reg_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4,
   parameter int IDX_W   = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       grant,
   output logic [WIDTH-1:0]         data_output,
   output logic [IDX_W-1:0]         owner,
   output logic                     write_done,
   output logic                     busy,
   output logic [7:0]               write_count
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] winner_q, winner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [7:0]       count_q, count_d;
   logic             done_q, done_d;

   // Scan ptr, ptr+1, ... modulo NUM_REQ so that the last winner has the lowest priority.
   logic             found;
   logic [IDX_W-1:0] pick;
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      data_d   = data_q;
      count_d  = count_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               winner_d = pick;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            data_d  = req_data[int'(winner_q)*WIDTH +: WIDTH];
            owner_d = winner_q;
            count_d = count_q + 8'd1;
            done_d  = 1'b1;
            ptr_d   = IDX_W'((int'(winner_q) + 1) % NUM_REQ);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         winner_q <= '0;
         ptr_q    <= '0;
         owner_q  <= '0;
         data_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         data_q   <= data_d;
         count_q  <= count_d;
         done_q   <= done_d;
      end
   end

   // Grant and busy decode from registered state only, with no path from req.
   always_comb begin
      grant = '0;
      if (state_q == WRITE) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(winner_q) == i) grant[i] = 1'b1;
         end
      end
   end

   assign busy        = (state_q == WRITE);
   assign data_output = data_q;
   assign owner       = owner_q;
   assign write_done  = done_q;
   assign write_count = count_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed self-checking bench for reg_share_arbiter (NUM_REQ=4, WIDTH=4).
// Inputs change 1ns after a rising edge, and outputs are checked at that point as well.
module tb_reg_share_arbiter;

   logic        clock;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic [3:0]  grant;
   logic [3:0]  data_output;
   logic [1:0]  owner;
   logic        write_done;
   logic        busy;
   logic [7:0]  write_count;

   int total = 0;
   int bad   = 0;

   reg_share_arbiter #(.NUM_REQ(4), .WIDTH(4), .IDX_W(2)) dut (
      .clock(clock), .reset(reset), .req(req), .req_data(req_data),
      .grant(grant), .data_output(data_output), .owner(owner),
      .write_done(write_done), .busy(busy), .write_count(write_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      req = 4'b0000;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      req = 4'b0000;
      req_data = 16'h0000;
      reset = 1'b1;
      #2;
      total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL reset_async grant=%b busy=%b want 0000/0", grant, busy); end
      repeat (3) tick();
      reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         total++; if (data_output !== 4'h0) begin bad++; $display("FAIL idle_data c=%0d got %h want 0", c, data_output); end
         total++; if (owner !== 2'd0) begin bad++; $display("FAIL idle_owner c=%0d got %0d want 0", c, owner); end
         total++; if (write_count !== 8'd0) begin bad++; $display("FAIL idle_count c=%0d got %0d want 0", c, write_count); end
         total++; if (grant !== 4'b0000 || busy !== 1'b0 || write_done !== 1'b0) begin bad++; $display("FAIL idle_ctl c=%0d grant=%b busy=%b done=%b want 0", c, grant, busy, write_done); end
      end
   endtask

   task automatic test_single();
      apply_reset();
      req_data = 16'h0A00;
      req = 4'b0100;
      tick();
      total++; if (grant !== 4'b0100 || busy !== 1'b1) begin bad++; $display("FAIL single_grant grant=%b busy=%b want 0100/1", grant, busy); end
      total++; if (data_output !== 4'h0 || write_done !== 1'b0) begin bad++; $display("FAIL single_early data=%h done=%b want 0/0", data_output, write_done); end
      req = 4'b0000;
      tick();
      total++; if (data_output !== 4'hA) begin bad++; $display("FAIL single_data got %h want a", data_output); end
      total++; if (owner !== 2'd2) begin bad++; $display("FAIL single_owner got %0d want 2", owner); end
      total++; if (write_done !== 1'b1 || write_count !== 8'd1) begin bad++; $display("FAIL single_done done=%b count=%0d want 1/1", write_done, write_count); end
      total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL single_release grant=%b busy=%b want 0000/0", grant, busy); end
      tick();
      total++; if (write_done !== 1'b0 || write_count !== 8'd1) begin bad++; $display("FAIL single_pulse done=%b count=%0d want 0/1", write_done, write_count); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      apply_reset();
      req_data = 16'h4321;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         exp_g = 4'b0001 << i;
         tick();
         total++; if (grant !== exp_g) begin bad++; $display("FAIL rr_grant i=%0d got %b want %b", i, grant, exp_g); end
         tick();
         total++; if (data_output !== 4'(i + 1) || owner !== 2'(i)) begin bad++; $display("FAIL rr_commit i=%0d data=%h owner=%0d want %0d/%0d", i, data_output, owner, i + 1, i); end
         total++; if (grant !== 4'b0000 || write_done !== 1'b1) begin bad++; $display("FAIL rr_idle i=%0d grant=%b done=%b want 0000/1", i, grant, write_done); end
      end
      req = 4'b0000;
      total++; if (write_count !== 8'd4) begin bad++; $display("FAIL rr_count got %0d want 4", write_count); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g;
      logic [1:0] exp_o;
      apply_reset();
      req_data = 16'h9005;
      req = 4'b1001;
      for (int i = 0; i < 4; i++) begin
         exp_o = (i % 2 == 0) ? 2'd0 : 2'd3;
         exp_g = (i % 2 == 0) ? 4'b0001 : 4'b1000;
         tick();
         total++; if (grant !== exp_g) begin bad++; $display("FAIL fair_grant i=%0d got %b want %b", i, grant, exp_g); end
         tick();
         total++; if (owner !== exp_o || data_output !== ((i % 2 == 0) ? 4'h5 : 4'h9)) begin bad++; $display("FAIL fair_owner i=%0d owner=%0d data=%h want %0d", i, owner, data_output, exp_o); end
      end
      req = 4'b0000;
   endtask

   task automatic test_mid_write_reset();
      apply_reset();
      req_data = 16'h0070;
      req = 4'b0010;
      tick();
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL mwr_grant got %b want 0010", grant); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (grant !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL mwr_drop grant=%b busy=%b want 0000/0", grant, busy); end
      req = 4'b0000;
      tick();
      total++; if (data_output !== 4'h0 || write_count !== 8'd0 || write_done !== 1'b0) begin bad++; $display("FAIL mwr_nocommit data=%h count=%0d done=%b want 0/0/0", data_output, write_count, write_done); end
      reset = 1'b0;
      tick();
      total++; if (busy !== 1'b0 || data_output !== 4'h0) begin bad++; $display("FAIL mwr_idle busy=%b data=%h want 0/0", busy, data_output); end
   endtask

   task automatic test_withdrawal();
      apply_reset();
      req_data = 16'h0050;
      req = 4'b0010;
      tick();
      total++; if (grant !== 4'b0010) begin bad++; $display("FAIL wd_grant got %b want 0010", grant); end
      req = 4'b0000;
      tick();
      total++; if (data_output !== 4'h5 || owner !== 2'd1 || write_count !== 8'd1) begin bad++; $display("FAIL wd_commit data=%h owner=%0d count=%0d want 5/1/1", data_output, owner, write_count); end
   endtask

   task automatic test_count_wrap();
      apply_reset();
      req_data = 16'h000C;
      req = 4'b0001;
      for (int i = 0; i < 255; i++) repeat (2) tick();
      total++; if (write_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got %0d want 255", write_count); end
      repeat (2) tick();
      req = 4'b0000;
      total++; if (write_count !== 8'd0) begin bad++; $display("FAIL wrap_0 got %0d want 0", write_count); end
      total++; if (data_output !== 4'hC || write_done !== 1'b1) begin bad++; $display("FAIL wrap_data data=%h done=%b want c/1", data_output, write_done); end
   endtask

   initial begin
      reset = 1'b1;
      req = 4'b0000;
      req_data = 16'h0000;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_mid_write_reset();
      test_withdrawal();
      test_count_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin write arbiter that shares one WIDTH-bit storage register among NUM_REQ requesters.
- Each requester raises a request with its data word. The arbiter grants exactly one requester per write slot and commits that requester's word into the shared register.
- It publishes the stored value, the index of the last writer, and a running write count.
- Sits between datapath producers and the 4-bit register storage used elsewhere in the design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, width of the data word and of the shared register.
- IDX_W, 2, width of the owner index; must equal ceil(log2(NUM_REQ)).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester write request, level-sensitive.
- req_data  input  NUM_REQ*WIDTH  flattened data words; requester i occupies bits [i*WIDTH +: WIDTH].
- grant  output  NUM_REQ  one-hot; high for exactly the single WRITE cycle of the winner.
- data_output  output  WIDTH  current contents of the shared register.
- owner  output  IDX_W  index of the most recent writer.
- write_done  output  1  one-cycle pulse in the cycle after a commit.
- busy  output  1  high while state is WRITE.
- write_count  output  8  number of commits, wraps 255 -> 0.

Behaviour:
- Reset (asynchronous, active-high; clock is clock): takes effect immediately, at any point including mid-WRITE. On reset:
  - state = IDLE; data_output = 0; owner = 0; write_count = 0; write_done = 0.
  - grant = 0; busy = 0; round-robin pointer ptr = 0.
  - An interrupted WRITE does not commit.
- FSM, two states:
  - IDLE:
    - If |req == 0, stay in IDLE.
    - Otherwise, at the edge: winner_q <= first index i with req[i] = 1, searching ptr, ptr+1, ... modulo NUM_REQ; state <= WRITE.
  - WRITE:
    - grant = onehot(winner_q) and busy = 1, both decoded from registered state only, with no combinational path from req.
    - At the edge ending WRITE:
      - register <= req_data[winner_q], sampled at that edge; owner <= winner_q.
      - write_count <= write_count + 1 (mod 256); write_done <= 1.
      - ptr <= (winner_q + 1) mod NUM_REQ; state <= IDLE.
- write_done is high for the one IDLE cycle following WRITE, otherwise 0.
- Latency:
  - req rising in cycle N (state IDLE) -> grant in cycle N+1.
  - data_output, owner and write_done update in cycle N+2.
- Throughput: at most one commit per 2 cycles, even with req held continuously.
- Requester protocol:
  - Hold req and a stable req_data until grant is seen.
  - Drop req at the edge ending the grant cycle.
  - A req still high in the following IDLE cycle is arbitrated again, as a new request.
- Withdrawal: if req[winner_q] drops during WRITE, the commit still happens, using whatever req_data[winner_q] holds at the edge.
- A change in req during WRITE does not affect the current grant. The new req is evaluated in the next IDLE cycle.
- Fairness: after requester i wins, i has the lowest priority. Any continuously requesting requester is granted within NUM_REQ slots.
- Pointer wrap: winner NUM_REQ-1 -> ptr = 0.
- Indices of req beyond NUM_REQ-1 do not exist. Non-power-of-2 NUM_REQ must never produce an owner index >= NUM_REQ.
- grant is always one-hot or zero; never more than one bit set.

Test Plan:
- Reset then idle: assert reset for 3 cycles, req = 0 for 10 cycles -> data_output = 0, owner = 0, write_count = 0, grant = 0, busy = 0 throughout.
- Single write: req = 4'b0100, req_data[11:8] = 4'hA in cycle N -> grant = 4'b0100 in N+1; data_output = 4'hA, owner = 2, write_done = 1, write_count = 1 in N+2.
- Round-robin: req = 4'b1111 held for 8 cycles, data i = 4'h1+i -> grants in order 0, 1, 2, 3, one every 2 cycles; data_output sequence 1, 2, 3, 4; write_count = 4.
- Fairness/wrap: req = 4'b1001 held, ptr = 0 after reset -> grants alternate 0, 3, 0, 3; owner alternates; no grant to 1 or 2.
- Mid-WRITE reset: req = 4'b0010 with data 4'h7, assert reset during the grant cycle -> grant drops immediately; data_output stays 0; write_count stays 0; state IDLE.
- Wrap and withdrawal: force 256 commits -> write_count reads 0. Separately, drop req[1] during the WRITE cycle with data 4'h5 -> commit still occurs, data_output = 4'h5.
